// File: rtl/dpb_slave_rd_stream_if.sv
// Byte-stream handshake between the BRAM read serialiser and its consumer.
// master drives data/valid/last, slave returns ready.
interface dpb_slave_rd_stream_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_last;
  logic       i_ready;

  modport master (
    output o_data,
    output o_valid,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/dpb_slave_rd_stream.sv
// Drains one 128-word buffer rank of the MJPEG dual-port BRAM (port B)
// as an MSB-first 8-bit valid/ready stream, one byte per clock.
module dpb_slave_rd_stream #(
  parameter int RD_LATENCY = 2,
  parameter int BUF_WORDS  = 128,
  parameter int ADDR_W     = 11
) (
  input  logic              i_pclk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [3:0]        i_buf_rank,
  input  logic [11:0]       i_byte_len,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  dpb_slave_rd_stream_if.master st,
  input  logic [127:0]      i_dpb_rd_data,
  output logic [ADDR_W-1:0] o_dpb_addr,
  output logic              o_dpb_clk,
  output logic              o_dpb_cea,
  output logic              o_dpb_ocea,
  output logic              o_dpb_rst_n,
  output logic              o_dpb_wr_en,
  output logic [127:0]      o_dpb_wr_data
);

  localparam int WIDX_W = $clog2(BUF_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [3:0]          r_rank;
  logic [11:0]         r_rem;
  logic [WIDX_W-1:0]   r_widx;
  logic [WIDX_W:0]     r_rd_left;
  logic [3:0]          r_bidx;
  logic [127:0]        r_shift;
  logic [127:0]        r_shad;
  logic [RD_LATENCY-1:0] r_vld;
  logic                r_valid;
  logic                r_last;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_cea;
  logic [ADDR_W-1:0]   r_addr;
  logic                w_hs;
  logic                w_rd_rdy;

  assign w_hs     = r_valid & st.i_ready;
  assign w_rd_rdy = r_vld[RD_LATENCY-1];

  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rank    <= '0;
      r_rem     <= '0;
      r_widx    <= '0;
      r_rd_left <= '0;
      r_bidx    <= '0;
      r_shift   <= '0;
      r_shad    <= '0;
      r_vld     <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_cea     <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_cea  <= 1'b0;
      r_done <= 1'b0;
      r_vld  <= {r_vld[RD_LATENCY-2:0], r_cea};
      if (r_state == S_STREAM && w_rd_rdy)
        r_shad <= i_dpb_rd_data;
      if (i_start && r_busy)
        r_error <= 1'b1;
      // abort drops in-flight reads so a later transfer never sees them
      if (i_abort && r_busy) begin
        r_state <= S_DONE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
        r_vld   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              if (i_byte_len > 12'd2048) begin
                r_error <= 1'b1;
              end else if (i_byte_len == 12'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_rank    <= i_buf_rank;
                r_rem     <= i_byte_len;
                r_rd_left <= (WIDX_W+1)'((i_byte_len + 12'd15) >> 4)
                             - (WIDX_W+1)'(1);
                r_widx    <= WIDX_W'(1);
                r_addr    <= {i_buf_rank, {WIDX_W{1'b0}}};
                r_cea     <= 1'b1;
                r_busy    <= 1'b1;
                r_state   <= S_FETCH;
              end
            end
          end
          S_FETCH: r_state <= S_WAIT;
          S_WAIT: begin
            if (w_rd_rdy) begin
              r_shift <= i_dpb_rd_data;
              r_bidx  <= '0;
              r_valid <= 1'b1;
              r_last  <= (r_rem == 12'd1);
              r_state <= S_STREAM;
              if (r_rd_left != '0) begin
                r_cea     <= 1'b1;
                r_addr    <= {r_rank, r_widx};
                r_widx    <= r_widx + WIDX_W'(1);
                r_rd_left <= r_rd_left - (WIDX_W+1)'(1);
              end
            end
          end
          S_STREAM: begin
            if (w_hs) begin
              r_rem <= r_rem - 12'd1;
              if (r_last) begin
                r_state <= S_DONE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_last <= (r_rem == 12'd2);
                r_bidx <= r_bidx + 4'd1;
                if (r_bidx == 4'd15) begin
                  r_shift <= r_shad;
                  if (r_rd_left != '0) begin
                    r_cea     <= 1'b1;
                    r_addr    <= {r_rank, r_widx};
                    r_widx    <= r_widx + WIDX_W'(1);
                    r_rd_left <= r_rd_left - (WIDX_W+1)'(1);
                  end
                end else begin
                  r_shift <= {r_shift[119:0], 8'h00};
                end
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign st.o_data    = r_shift[127:120];
  assign st.o_valid   = r_valid;
  assign st.o_last    = r_last;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_dpb_addr   = r_addr;
  assign o_dpb_cea    = r_cea;
  assign o_dpb_clk    = i_pclk;
  assign o_dpb_ocea   = 1'b1;
  assign o_dpb_rst_n  = i_rst_n;
  assign o_dpb_wr_en  = 1'b0;
  assign o_dpb_wr_data = '0;

endmodule
